// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_sequencer
// Description : Job controller for a weight-stationary systolic array: loads
//               weight rows, streams skewed data vectors, deskews column sums
//               into a credit-managed result FIFO.
//               Optional macro SYSTOLIC_SEQ_PERF_EN adds a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_sequencer #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int ARRAY_LAT   = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [15:0]                          num_vectors,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] w_row,
    input  logic                                 d_valid,
    output logic                                 d_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] d_vec,
    output logic                                 arr_ld_weight,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_in_weights,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_in_data,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_out_sum,
    output logic                                 r_valid,
    input  logic                                 r_ready,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] r_vec,
    output logic                                 busy,
`ifdef SYSTOLIC_SEQ_PERF_EN
    output logic [31:0]                          stall_cycles,
`endif
    output logic                                 done
);

    localparam int c_TAG_DEPTH = ARRAY_LAT + MATRIX_SIZE - 1;
    localparam int c_PW        = $clog2(FIFO_DEPTH);
    localparam int c_CW        = $clog2(FIFO_DEPTH + c_TAG_DEPTH + 1);
    localparam int c_RW        = $clog2(MATRIX_SIZE + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD_W = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

    logic [1:0]                             r_state;
    logic [1:0]                             w_state_next;
    logic [c_RW-1:0]                        r_row_cnt;
    logic [15:0]                            r_remaining;
    logic [c_TAG_DEPTH-1:0]                 r_tag;
    logic [c_CW-1:0]                        r_count;
    logic [c_CW-1:0]                        w_inflight;
    logic [c_CW-1:0]                        w_mem_count;
    logic [c_PW-1:0]                        r_wr_ptr;
    logic [c_PW-1:0]                        r_rd_ptr;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  r_mem [FIFO_DEPTH];
    logic                                   r_head_valid;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  r_head_vec;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  w_aligned;
    logic                                   w_wt_accept;
    logic                                   w_dv_accept;
    logic                                   w_has_credit;
    logic                                   w_start_ok;
    logic                                   w_push;
    logic                                   w_pop;
    logic                                   w_load_head;
    logic                                   w_from_mem;
    logic                                   w_bypass;
    logic                                   w_mem_wr;

    assign w_start_ok  = (r_state == c_ST_IDLE) && start;
    assign w_wt_accept = w_valid && w_ready;
    assign w_dv_accept = d_valid && d_ready;
    assign busy        = (r_state != c_ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        d_ready      = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_next = c_ST_LOAD_W;
            end
            c_ST_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (r_row_cnt == c_RW'(MATRIX_SIZE - 1)))
                    w_state_next = (r_remaining != '0) ? c_ST_STREAM : c_ST_DRAIN;
            end
            c_ST_STREAM: begin
                d_ready = (r_remaining != '0) && w_has_credit;
                if (d_valid && d_ready && (r_remaining == 16'd1))
                    w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if ((r_tag == '0) && (r_count == '0)) begin
                    done         = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_cnt   <= '0;
            r_remaining <= '0;
        end else begin
            if (w_start_ok) begin
                r_row_cnt   <= '0;
                r_remaining <= num_vectors;
            end
            if (w_wt_accept) r_row_cnt <= r_row_cnt + c_RW'(1);
            if (w_dv_accept) r_remaining <= r_remaining - 16'd1;
        end
    end

    assign arr_ld_weight  = w_wt_accept;
    assign arr_in_weights = w_wt_accept ? w_row : '0;

    // Lane k is skewed by k stages on the way in and by MATRIX_SIZE-1-k on
    // the way out, so every lane of a result vector lines up in one cycle.
    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        localparam int c_DLY = MATRIX_SIZE - 1 - k;
        logic [DATA_SIZE-1:0] w_lane_in;
        assign w_lane_in = w_dv_accept ? d_vec[k] : '0;

        if (k == 0) begin : g_direct
            assign arr_in_data[k] = w_lane_in;
        end else begin : g_skew
            logic [DATA_SIZE-1:0] r_sk [k];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < k; s++) r_sk[s] <= '0;
                end else begin
                    r_sk[0] <= w_lane_in;
                    for (int s = 1; s < k; s++) r_sk[s] <= r_sk[s-1];
                end
            end
            assign arr_in_data[k] = r_sk[k-1];
        end

        if (c_DLY == 0) begin : g_align
            assign w_aligned[k] = arr_out_sum[k];
        end else begin : g_deskew
            logic [DATA_SIZE-1:0] r_ds [c_DLY];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < c_DLY; s++) r_ds[s] <= '0;
                end else begin
                    r_ds[0] <= arr_out_sum[k];
                    for (int s = 1; s < c_DLY; s++) r_ds[s] <= r_ds[s-1];
                end
            end
            assign w_aligned[k] = r_ds[c_DLY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_dv_accept;
            for (int i = 1; i < c_TAG_DEPTH; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Tagged vectors still in the array already own a FIFO slot.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_TAG_DEPTH; i++) w_inflight = w_inflight + c_CW'(r_tag[i]);
    end
    assign w_has_credit = (r_count + w_inflight) < c_CW'(FIFO_DEPTH);

    // The head register holds the oldest entry; r_count includes it.
    assign w_push      = r_tag[c_TAG_DEPTH-1];
    assign w_pop       = r_head_valid && r_ready;
    assign w_mem_count = r_count - c_CW'(r_head_valid);
    assign w_load_head = !r_head_valid || w_pop;
    assign w_from_mem  = w_load_head && (w_mem_count != '0);
    assign w_bypass    = w_load_head && !w_from_mem && w_push;
    assign w_mem_wr    = w_push && !w_bypass;

    always_ff @(posedge clk) begin
        if (w_mem_wr) r_mem[r_wr_ptr] <= w_aligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head_vec   <= '0;
        end else begin
            if (w_mem_wr) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_from_mem) begin
                r_head_vec   <= r_mem[r_rd_ptr];
                r_head_valid <= 1'b1;
                r_rd_ptr     <= r_rd_ptr + c_PW'(1);
            end else if (w_bypass) begin
                r_head_vec   <= w_aligned;
                r_head_valid <= 1'b1;
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    assign r_valid = r_head_valid;
    assign r_vec   = r_head_vec;

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_ST_STREAM) && d_valid && !d_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_sequencer
// Description : Directed self-checking bench for systolic_sequencer with a
//               behavioural weight-stationary array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_sequencer;

    localparam int MS = 2;
    localparam int DW = 32;
    localparam int AL = 2;
    localparam int FD = 4;

    typedef logic [MS-1:0][DW-1:0] vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vectors = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    vec_t        w_row = '0;
    logic        d_valid = 1'b0;
    logic        d_ready;
    vec_t        d_vec = '0;
    logic        arr_ld_weight;
    vec_t        arr_in_weights;
    vec_t        arr_in_data;
    vec_t        arr_out_sum = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    vec_t        r_vec;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    systolic_sequencer #(
        .MATRIX_SIZE(MS), .DATA_SIZE(DW), .ARRAY_LAT(AL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .d_valid(d_valid), .d_ready(d_ready), .d_vec(d_vec),
        .arr_ld_weight(arr_ld_weight), .arr_in_weights(arr_in_weights),
        .arr_in_data(arr_in_data), .arr_out_sum(arr_out_sum),
        .r_valid(r_valid), .r_ready(r_ready), .r_vec(r_vec),
        .busy(busy), .done(done)
    );

    // Array model: weights shift down on load; lane j of the sum for the
    // vector whose lane 0 entered at cycle t appears at cycle t+AL+j.
    vec_t hist [256];
    vec_t wm [MS];
    always @(posedge clk) begin : model
        vec_t nxt;
        logic [DW-1:0] acc;
        if (arr_ld_weight) begin
            for (int i = MS - 1; i > 0; i--) wm[i] = wm[i-1];
            wm[0] = arr_in_weights;
        end
        hist[cyc & 255] = arr_in_data;
        cyc = cyc + 1;
        for (int j = 0; j < MS; j++) begin
            acc = '0;
            for (int i = 0; i < MS; i++) acc = acc + wm[i][j] * hist[(cyc - AL - j + i) & 255][i];
            nxt[j] = acc;
        end
        arr_out_sum <= nxt;
    end

    vec_t res_q[$];
    int   res_cyc_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rv_seen  = 0;
    always @(negedge clk) begin
        if (!reset && r_valid && r_ready) begin
            res_q.push_back(r_vec);
            res_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (r_valid) rv_seen = rv_seen + 1;
    end

    function automatic vec_t mk(input int a, input int b);
        vec_t v;
        v[0] = DW'(a);
        v[1] = DW'(b);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        res_q.delete();
        res_cyc_q.delete();
        done_cnt = 0;
        rv_seen  = 0;
    endtask

    // Start a job and load rows {5,6} then {7,8}; returns in the first
    // cycle after the last row.
    task automatic start_job(input int n);
        tick(); start = 1'b1; num_vectors = 16'(n);
        tick(); start = 1'b0; w_valid = 1'b1; w_row = mk(5, 6);
        tick(); w_row = mk(7, 8);
        tick(); w_valid = 1'b0; w_row = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (r_valid !== 1'b0 || r_vec !== '0) begin bad++; $display("FAIL rst_result: got %b/%h want 0/0", r_valid, r_vec); end
        tick(); reset = 1'b0; start = 1'b1; num_vectors = 16'd3;
        tick(); start = 1'b0; w_valid = 1'b1; w_row = mk(9, 9);
        @(negedge clk);
        total++; if (arr_ld_weight !== 1'b1) begin bad++; $display("FAIL rst_pre_ld: got %b want 1", arr_ld_weight); end
        tick();
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || w_ready !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got busy=%b w_ready=%b want 0/0", busy, w_ready); end
        total++; if (arr_ld_weight !== 1'b0 || arr_in_weights !== '0) begin bad++; $display("FAIL rst_async_w: got %b/%h want 0/0", arr_ld_weight, arr_in_weights); end
        total++; if (d_ready !== 1'b0 || done !== 1'b0 || r_valid !== 1'b0 || r_vec !== '0 || arr_in_data !== '0) begin
            bad++; $display("FAIL rst_async_out: got d_ready=%b done=%b r_valid=%b r_vec=%h data=%h want all 0", d_ready, done, r_valid, r_vec, arr_in_data);
        end
        tick(); w_valid = 1'b0; w_row = '0;
        tick(); reset = 1'b0;
    endtask

    task automatic test_weight_load();
        tick(); start = 1'b1; num_vectors = 16'd3; r_ready = 1'b1;
        tick(); start = 1'b0; w_valid = 1'b1; w_row = mk(5, 6);
        @(negedge clk);
        total++; if (arr_ld_weight !== 1'b1 || arr_in_weights !== mk(5, 6)) begin bad++; $display("FAIL wl_row0: got %b/%h want 1/%h", arr_ld_weight, arr_in_weights, mk(5, 6)); end
        total++; if (busy !== 1'b1 || w_ready !== 1'b1) begin bad++; $display("FAIL wl_busy: got busy=%b w_ready=%b want 1/1", busy, w_ready); end
        tick(); w_row = mk(7, 8);
        @(negedge clk);
        total++; if (arr_ld_weight !== 1'b1 || arr_in_weights !== mk(7, 8)) begin bad++; $display("FAIL wl_row1: got %b/%h want 1/%h", arr_ld_weight, arr_in_weights, mk(7, 8)); end
        tick(); w_row = mk(9, 9);
        @(negedge clk);
        total++; if (w_ready !== 1'b0 || arr_ld_weight !== 1'b0 || arr_in_weights !== '0) begin
            bad++; $display("FAIL wl_after: got w_ready=%b ld=%b w=%h want 0/0/0", w_ready, arr_ld_weight, arr_in_weights);
        end
    endtask

    task automatic test_stream();
        vec_t vin [3];
        vec_t exp_r [3];
        logic [DW-1:0] exp_l1 [3];
        int t0;
        vin[0] = mk(1, 2);   vin[1] = mk(3, 4);   vin[2] = mk(5, 6);
        exp_r[0] = mk(17, 20); exp_r[1] = mk(41, 48); exp_r[2] = mk(65, 76);
        exp_l1[0] = 32'd0;   exp_l1[1] = 32'd2;   exp_l1[2] = 32'd4;
        t0 = 0;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            tick(); w_valid = 1'b0; w_row = '0; d_valid = 1'b1; d_vec = vin[i];
            @(negedge clk);
            if (i == 0) t0 = cyc;
            total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL st_dready%0d: got %b want 1", i, d_ready); end
            total++; if (arr_in_data[0] !== vin[i][0] || arr_in_data[1] !== exp_l1[i]) begin
                bad++; $display("FAIL st_skew%0d: got %h/%h want %h/%h", i, arr_in_data[0], arr_in_data[1], vin[i][0], exp_l1[i]);
            end
        end
        tick(); d_valid = 1'b0; d_vec = '0;
        @(negedge clk);
        total++; if (arr_in_data[0] !== 32'd0 || arr_in_data[1] !== 32'd6 || d_ready !== 1'b0) begin
            bad++; $display("FAIL st_tail: got %h/%h d_ready=%b want 0/6/0", arr_in_data[0], arr_in_data[1], d_ready);
        end
        for (int i = 0; i < 30 && done_cnt == 0; i++) tick();
        tick(); tick();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL st_done_cnt: got %0d want 1", done_cnt); end
        total++; if (res_q.size() != 3) begin bad++; $display("FAIL st_count: got %0d want 3", res_q.size()); end
        for (int k = 0; k < 3 && k < res_q.size(); k++) begin
            total++; if (res_q[k] !== exp_r[k]) begin bad++; $display("FAIL st_res%0d: got %h want %h", k, res_q[k], exp_r[k]); end
            total++; if (res_cyc_q[k] != t0 + 4 + k) begin bad++; $display("FAIL st_lat%0d: got cycle %0d want %0d", k, res_cyc_q[k], t0 + 4 + k); end
        end
        total++; if (done_cyc != t0 + 7) begin bad++; $display("FAIL st_done_cyc: got %0d want %0d", done_cyc, t0 + 7); end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        r_ready = 1'b0;
        clear_mon();
        start_job(8);
        for (int i = 0; i < 12; i++) begin
            d_valid = 1'b1; d_vec = mk(acc + 1, 2 * (acc + 1));
            @(negedge clk);
            if (d_ready) acc++;
            tick();
        end
        @(negedge clk);
        total++; if (acc != 4) begin bad++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        total++; if (d_ready !== 1'b0 || r_valid !== 1'b1) begin bad++; $display("FAIL bp_stall: got d_ready=%b r_valid=%b want 0/1", d_ready, r_valid); end
        tick();
        @(negedge clk);
        total++; if (r_vec !== mk(17, 20)) begin bad++; $display("FAIL bp_hold: got %h want %h", r_vec, mk(17, 20)); end
        tick(); r_ready = 1'b1;
        for (int i = 0; i < 100 && acc < 8; i++) begin
            d_valid = 1'b1; d_vec = mk(acc + 1, 2 * (acc + 1));
            @(negedge clk);
            if (d_ready) acc++;
            tick();
        end
        d_valid = 1'b0; d_vec = '0;
        for (int i = 0; i < 50 && done_cnt == 0; i++) tick();
        total++; if (acc != 8) begin bad++; $display("FAIL bp_total_acc: got %0d want 8", acc); end
        total++; if (res_q.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", res_q.size()); end
        for (int k = 0; k < 8 && k < res_q.size(); k++) begin
            total++; if (res_q[k] !== mk(17 * (k + 1), 20 * (k + 1))) begin
                bad++; $display("FAIL bp_res%0d: got %h want %h", k, res_q[k], mk(17 * (k + 1), 20 * (k + 1)));
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_empty_job();
        clear_mon();
        start_job(0);
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ej_done: got done=%b busy=%b want 1/1", done, busy); end
        tick();
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ej_idle: got done=%b busy=%b want 0/0", done, busy); end
        for (int i = 0; i < 8; i++) tick();
        total++; if (rv_seen != 0 || done_cnt != 1) begin bad++; $display("FAIL ej_quiet: got rv=%0d done=%0d want 0/1", rv_seen, done_cnt); end
    endtask

    task automatic test_reset_mid_stream();
        r_ready = 1'b1;
        start_job(4);
        d_valid = 1'b1; d_vec = mk(1, 2);
        tick(); d_vec = mk(3, 4);
        tick(); d_valid = 1'b0; d_vec = '0;
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || r_valid !== 1'b0 || d_ready !== 1'b0) begin
            bad++; $display("FAIL rm_reset: got busy=%b r_valid=%b d_ready=%b want 0/0/0", busy, r_valid, d_ready);
        end
        tick(); tick(); reset = 1'b0;
        clear_mon();
        for (int i = 0; i < 6; i++) tick();
        total++; if (rv_seen != 0) begin bad++; $display("FAIL rm_flushed: got rv=%0d want 0", rv_seen); end
        start_job(2);
        d_valid = 1'b1; d_vec = mk(3, 4);
        @(negedge clk);
        total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL rm_acc0: got %b want 1", d_ready); end
        tick(); d_vec = mk(5, 6);
        @(negedge clk);
        total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL rm_acc1: got %b want 1", d_ready); end
        tick(); d_valid = 1'b0; d_vec = '0;
        for (int i = 0; i < 30 && done_cnt == 0; i++) tick();
        total++; if (res_q.size() != 2 || done_cnt != 1) begin bad++; $display("FAIL rm_count: got %0d results %0d done want 2/1", res_q.size(), done_cnt); end
        if (res_q.size() >= 2) begin
            total++; if (res_q[0] !== mk(41, 48)) begin bad++; $display("FAIL rm_res0: got %h want %h", res_q[0], mk(41, 48)); end
            total++; if (res_q[1] !== mk(65, 76)) begin bad++; $display("FAIL rm_res1: got %h want %h", res_q[1], mk(65, 76)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) hist[i] = '0;
        for (int i = 0; i < MS; i++) wm[i] = '0;
        #1 reset = 1'b1;
        test_reset();
        test_weight_load();
        test_stream();
        test_backpressure();
        test_empty_job();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
